// File: rtl/pd_pkg.sv
// Shared types for the decode/execute pipeline boundary.
// Holds datapath widths, the control bundle layout and the bubble encoding.
// Imported by id_ex_stage and load_use_detect.
package pd_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detector: flags a decode instruction that reads the register a load in execute writes.
// Latency: purely combinational, stall is valid in the same cycle as its inputs.
// Backpressure: stall holds fetch/decode; a taken flush suppresses it because the decode instruction dies anyway.
module load_use_detect #(
  parameter int ADDR_W = pd_pkg::REG_ADDR_W
) (
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_addr_rs1,
  input  logic [ADDR_W-1:0] id_addr_rs2,
  input  logic [1:0]        id_rs_used,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [ADDR_W-1:0] ex_addr_rd,
  input  logic              ex_flush,
  output logic              stall
);

  logic rs1_hit;
  logic rs2_hit;

  // Stall only when a live load targets a non-zero register that decode actually reads
  always_comb begin
    rs1_hit = id_rs_used[0] && (id_addr_rs1 == ex_addr_rd);
    rs2_hit = id_rs_used[1] && (id_addr_rs2 == ex_addr_rd);
    stall   = id_valid && ex_valid && ex_mem_read && (ex_addr_rd != '0) &&
              !ex_flush && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with write-back bypass, load-use stall and a stall-cycle counter.
// Latency: 1 cycle from decode fields to ex_* outputs; stall is combinational.
// Backpressure: on a hazard, stall holds upstream and a bubble enters execute; flush overrides stall.
module id_ex_stage
  import pd_pkg::*;
#(
  parameter int XLEN   = pd_pkg::XLEN,
  parameter int ADDR_W = pd_pkg::REG_ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [31:0]       id_insn,
  input  logic [XLEN-1:0]   id_imm,
  input  ctrl_t             id_ctrl,
  input  logic [ADDR_W-1:0] id_addr_rs1,
  input  logic [ADDR_W-1:0] id_addr_rs2,
  input  logic [1:0]        id_rs_used,
  input  logic [ADDR_W-1:0] id_addr_rd,
  input  logic [XLEN-1:0]   data_rs1,
  input  logic [XLEN-1:0]   data_rs2,
  input  logic              wb_write_enable,
  input  logic [ADDR_W-1:0] wb_addr_rd,
  input  logic [XLEN-1:0]   wb_data_rd,
  input  logic              ex_flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [31:0]       ex_insn,
  output logic [XLEN-1:0]   ex_imm,
  output ctrl_t             ex_ctrl,
  output logic [ADDR_W-1:0] ex_addr_rd,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [CNT_W-1:0]  stall_count
);

  logic              valid_q,   valid_d;
  logic [XLEN-1:0]   pc_q,      pc_d;
  logic [31:0]       insn_q,    insn_d;
  logic [XLEN-1:0]   imm_q,     imm_d;
  ctrl_t             ctrl_q,    ctrl_d;
  logic [ADDR_W-1:0] rd_q,      rd_d;
  logic [XLEN-1:0]   rs1_q,     rs1_d;
  logic [XLEN-1:0]   rs2_q,     rs2_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [XLEN-1:0]   rs1_byp;
  logic [XLEN-1:0]   rs2_byp;

  load_use_detect #(
    .ADDR_W (ADDR_W)
  ) u_load_use_detect (
    .id_valid    (id_valid),
    .id_addr_rs1 (id_addr_rs1),
    .id_addr_rs2 (id_addr_rs2),
    .id_rs_used  (id_rs_used),
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_addr_rd  (rd_q),
    .ex_flush    (ex_flush),
    .stall       (stall)
  );

  // Write-through bypass: x0 reads zero, a same-cycle write-back wins over the stale register file data
  always_comb begin
    if (id_addr_rs1 == '0) begin
      rs1_byp = '0;
    end else if (wb_write_enable && (wb_addr_rd == id_addr_rs1)) begin
      rs1_byp = wb_data_rd;
    end else begin
      rs1_byp = data_rs1;
    end
    if (id_addr_rs2 == '0) begin
      rs2_byp = '0;
    end else if (wb_write_enable && (wb_addr_rd == id_addr_rs2)) begin
      rs2_byp = wb_data_rd;
    end else begin
      rs2_byp = data_rs2;
    end
  end

  // Next execute contents: bubble by default, capture only a live, unstalled, unflushed instruction
  always_comb begin
    valid_d = 1'b0;
    pc_d    = '0;
    insn_d  = '0;
    imm_d   = '0;
    ctrl_d  = CTRL_BUBBLE;
    rd_d    = '0;
    rs1_d   = '0;
    rs2_d   = '0;
    if (!ex_flush && !stall && id_valid) begin
      valid_d = 1'b1;
      pc_d    = id_pc;
      insn_d  = id_insn;
      imm_d   = id_imm;
      ctrl_d  = id_ctrl;
      rd_d    = id_addr_rd;
      rs1_d   = rs1_byp;
      rs2_d   = rs2_byp;
    end
  end

  // Saturating stall-cycle counter so a long-running count never wraps back to a small value
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Pipeline and counter state, cleared asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      insn_q  <= '0;
      imm_q   <= '0;
      ctrl_q  <= CTRL_BUBBLE;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      insn_q  <= insn_d;
      imm_q   <= imm_d;
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_insn     = insn_q;
  assign ex_imm      = imm_q;
  assign ex_ctrl     = ctrl_q;
  assign ex_addr_rd  = rd_q;
  assign ex_rs1_data = rs1_q;
  assign ex_rs2_data = rs2_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vectors, a behavioural model checked every negedge, and literal spot checks.
// Two instances share stimulus: default counter width and a 4-bit counter to exercise saturation.
module tb_id_ex_stage;
  import pd_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_pc = '0, id_insn = '0, id_imm = '0;
  logic [2:0]  id_ctrl = '0;
  logic [4:0]  id_addr_rs1 = '0, id_addr_rs2 = '0, id_addr_rd = '0;
  logic [1:0]  id_rs_used = '0;
  logic [31:0] data_rs1 = '0, data_rs2 = '0;
  logic        wb_write_enable = 1'b0;
  logic [4:0]  wb_addr_rd = '0;
  logic [31:0] wb_data_rd = '0;
  logic        ex_flush = 1'b0;

  logic        a_stall, a_valid, b_stall, b_valid;
  logic [31:0] a_pc, a_insn, a_imm, a_rs1, a_rs2, b_pc, b_insn, b_imm, b_rs1, b_rs2;
  logic [2:0]  a_ctrl, b_ctrl;
  logic [4:0]  a_rd, b_rd;
  logic [31:0] a_cnt;
  logic [3:0]  b_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  id_ex_stage dut_a (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_insn(id_insn),
    .id_imm(id_imm), .id_ctrl(id_ctrl), .id_addr_rs1(id_addr_rs1), .id_addr_rs2(id_addr_rs2),
    .id_rs_used(id_rs_used), .id_addr_rd(id_addr_rd), .data_rs1(data_rs1), .data_rs2(data_rs2),
    .wb_write_enable(wb_write_enable), .wb_addr_rd(wb_addr_rd), .wb_data_rd(wb_data_rd),
    .ex_flush(ex_flush), .stall(a_stall), .ex_valid(a_valid), .ex_pc(a_pc), .ex_insn(a_insn),
    .ex_imm(a_imm), .ex_ctrl(a_ctrl), .ex_addr_rd(a_rd), .ex_rs1_data(a_rs1),
    .ex_rs2_data(a_rs2), .stall_count(a_cnt)
  );

  id_ex_stage #(.CNT_W(4)) dut_b (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_insn(id_insn),
    .id_imm(id_imm), .id_ctrl(id_ctrl), .id_addr_rs1(id_addr_rs1), .id_addr_rs2(id_addr_rs2),
    .id_rs_used(id_rs_used), .id_addr_rd(id_addr_rd), .data_rs1(data_rs1), .data_rs2(data_rs2),
    .wb_write_enable(wb_write_enable), .wb_addr_rd(wb_addr_rd), .wb_data_rd(wb_data_rd),
    .ex_flush(ex_flush), .stall(b_stall), .ex_valid(b_valid), .ex_pc(b_pc), .ex_insn(b_insn),
    .ex_imm(b_imm), .ex_ctrl(b_ctrl), .ex_addr_rd(b_rd), .ex_rs1_data(b_rs1),
    .ex_rs2_data(b_rs2), .stall_count(b_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = '0, m_insn = '0, m_imm = '0, m_rs1 = '0, m_rs2 = '0;
  logic [2:0]  m_ctrl = '0;
  logic [4:0]  m_rd = '0;
  longint      m_cnt_a = 0, m_cnt_b = 0;

  function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return 32'h0;
    if (wb_write_enable && wb_addr_rd == a) return wb_data_rd;
    return rf;
  endfunction

  // Execute holds a load whose destination the decode instruction reads
  function automatic logic model_stall();
    logic reads_it;
    reads_it = (id_rs_used[0] && id_addr_rs1 == m_rd) || (id_rs_used[1] && id_addr_rs2 == m_rd);
    return id_valid && m_valid && m_ctrl[1] && m_rd != 5'd0 && !ex_flush && reads_it;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0; m_pc <= '0; m_insn <= '0; m_imm <= '0; m_ctrl <= '0;
      m_rd <= '0; m_rs1 <= '0; m_rs2 <= '0; m_cnt_a <= 0; m_cnt_b <= 0;
    end else begin
      if (model_stall()) begin
        m_cnt_a <= (m_cnt_a < 64'hFFFF_FFFF) ? m_cnt_a + 1 : m_cnt_a;
        m_cnt_b <= (m_cnt_b < 15) ? m_cnt_b + 1 : m_cnt_b;
      end
      if (ex_flush || model_stall() || !id_valid) begin
        m_valid <= 1'b0; m_pc <= '0; m_insn <= '0; m_imm <= '0; m_ctrl <= '0;
        m_rd <= '0; m_rs1 <= '0; m_rs2 <= '0;
      end else begin
        m_valid <= 1'b1; m_pc <= id_pc; m_insn <= id_insn; m_imm <= id_imm; m_ctrl <= id_ctrl;
        m_rd <= id_addr_rd; m_rs1 <= operand(id_addr_rs1, data_rs1);
        m_rs2 <= operand(id_addr_rs2, data_rs2);
      end
    end
  end

  // Compare both instances against the model mid-cycle
  always @(negedge clock) begin
    chk("stall", {31'b0, a_stall}, {31'b0, model_stall()});
    chk("ex_valid", {31'b0, a_valid}, {31'b0, m_valid});
    chk("ex_pc", a_pc, m_pc);
    chk("ex_insn", a_insn, m_insn);
    chk("ex_imm", a_imm, m_imm);
    chk("ex_ctrl", {29'b0, a_ctrl}, {29'b0, m_ctrl});
    chk("ex_addr_rd", {27'b0, a_rd}, {27'b0, m_rd});
    chk("ex_rs1_data", a_rs1, m_rs1);
    chk("ex_rs2_data", a_rs2, m_rs2);
    chk("stall_count", a_cnt, m_cnt_a[31:0]);
    chk("b_stall", {31'b0, b_stall}, {31'b0, model_stall()});
    chk("b_ex_rd", {27'b0, b_rd}, {27'b0, m_rd});
    chk("b_stall_count", {28'b0, b_cnt}, m_cnt_b[31:0]);
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [2:0] ctrl,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [1:0] used,
                       input logic [4:0] rd);
    id_valid = v; id_pc = pc; id_insn = pc ^ 32'h0000_0033; id_imm = pc + 32'd4;
    id_ctrl = ctrl; id_addr_rs1 = rs1; id_addr_rs2 = rs2; id_rs_used = used; id_addr_rd = rd;
  endtask

  initial begin
    #1 reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    chk("reset ex_valid", {31'b0, a_valid}, 32'd0);
    chk("reset stall_count", a_cnt, 32'd0);

    // Bypass: write-back to rs1 overrides register file data
    drive(1'b1, 32'h100, 3'b100, 5'd5, 5'd6, 2'b11, 5'd9);
    data_rs1 = 32'h11; data_rs2 = 32'h22;
    wb_write_enable = 1'b1; wb_addr_rd = 5'd5; wb_data_rd = 32'hDEADBEEF;
    cyc();
    chk("bypass rs1", a_rs1, 32'hDEADBEEF);
    chk("no bypass rs2", a_rs2, 32'h22);
    chk("capture pc", a_pc, 32'h100);
    chk("capture rd", {27'b0, a_rd}, 32'd9);
    id_addr_rs1 = 5'd0;
    cyc();
    chk("x0 reads zero", a_rs1, 32'd0);
    id_addr_rs1 = 5'd5; wb_write_enable = 1'b0;
    cyc();
    chk("wb disabled", a_rs1, 32'h11);
    wb_write_enable = 1'b1; wb_addr_rd = 5'd6; wb_data_rd = 32'hCAFE0001;
    cyc();
    chk("bypass rs2", a_rs2, 32'hCAFE0001);
    wb_write_enable = 1'b0;

    // Load-use on rs1/rs2
    drive(1'b1, 32'h200, 3'b110, 5'd2, 5'd0, 2'b01, 5'd7);
    cyc();
    drive(1'b1, 32'h204, 3'b100, 5'd7, 5'd1, 2'b11, 5'd8);
    #2 chk("load-use stall", {31'b0, a_stall}, 32'd1);
    cyc();
    chk("bubble valid", {31'b0, a_valid}, 32'd0);
    chk("bubble ctrl", {29'b0, a_ctrl}, 32'd0);
    chk("count after stall", a_cnt, 32'd1);
    chk("stall dropped", {31'b0, a_stall}, 32'd0);
    cyc();
    chk("held insn captured", {27'b0, a_rd}, 32'd8);
    chk("held insn valid", {31'b0, a_valid}, 32'd1);
    drive(1'b1, 32'h300, 3'b110, 5'd2, 5'd0, 2'b00, 5'd7);
    cyc();
    drive(1'b1, 32'h304, 3'b100, 5'd1, 5'd7, 2'b10, 5'd9);
    #2 chk("rs2 load-use stall", {31'b0, a_stall}, 32'd1);
    cyc(); cyc();
    chk("count two stalls", a_cnt, 32'd2);
    chk("rs2 insn captured", {27'b0, a_rd}, 32'd9);

    // No hazard: operands not read, or load to x0
    drive(1'b1, 32'h400, 3'b110, 5'd2, 5'd0, 2'b00, 5'd7);
    cyc();
    drive(1'b1, 32'h404, 3'b100, 5'd7, 5'd1, 2'b00, 5'd8);
    #2 chk("unused operands no stall", {31'b0, a_stall}, 32'd0);
    cyc();
    chk("captured first edge", {27'b0, a_rd}, 32'd8);
    drive(1'b1, 32'h408, 3'b110, 5'd2, 5'd0, 2'b00, 5'd0);
    cyc();
    drive(1'b1, 32'h40C, 3'b100, 5'd0, 5'd0, 2'b11, 5'd8);
    #2 chk("load x0 no stall", {31'b0, a_stall}, 32'd0);
    cyc();
    chk("x0 case captured", a_pc, 32'h40C);

    // Flush beats hazard
    drive(1'b1, 32'h500, 3'b110, 5'd2, 5'd0, 2'b00, 5'd7);
    cyc();
    drive(1'b1, 32'h504, 3'b100, 5'd7, 5'd1, 2'b11, 5'd8);
    ex_flush = 1'b1;
    #2 chk("flush hides stall", {31'b0, a_stall}, 32'd0);
    cyc();
    chk("flush bubble", {31'b0, a_valid}, 32'd0);
    chk("flush count unchanged", a_cnt, 32'd2);
    ex_flush = 1'b0; id_valid = 1'b0;
    cyc();

    // Saturation: 20 stall cycles on a 4-bit counter
    drive(1'b1, 32'h600, 3'b110, 5'd3, 5'd0, 2'b00, 5'd7);
    cyc();
    drive(1'b1, 32'h604, 3'b110, 5'd7, 5'd0, 2'b01, 5'd7);
    for (int i = 0; i < 40; i++) cyc();
    id_valid = 1'b0;
    cyc();
    chk("count wide", a_cnt, 32'd22);
    chk("count saturated", {28'b0, b_cnt}, 32'd15);
    cyc();
    chk("count stays saturated", {28'b0, b_cnt}, 32'd15);

    // Asynchronous reset mid-stream
    drive(1'b1, 32'h700, 3'b100, 5'd1, 5'd2, 2'b11, 5'd4);
    cyc();
    reset = 1'b1;
    #1;
    chk("async ex_valid", {31'b0, a_valid}, 32'd0);
    chk("async ex_pc", a_pc, 32'd0);
    chk("async ex_rd", {27'b0, a_rd}, 32'd0);
    chk("async count", a_cnt, 32'd0);
    chk("async count b", {28'b0, b_cnt}, 32'd0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("post reset capture", a_pc, 32'h700);
    id_valid = 1'b0;
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
